// File: rtl/seg_scan_driver.sv
`default_nettype none
// =============================================================================
// seg_scan_driver : 4-digit time-multiplexed seven-segment driver with a
//                   blanking gap between digits and a per-slot value snapshot.
// Revision: 1.0
// =============================================================================
module seg_scan_driver #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  enable,
  output logic [6:0]  segs,
  output logic        decimal,
  output logic [1:0]  digit_idx
);

  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_drive_last = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [3:0]       r_hold_val, w_hold_val_nxt;
  logic             r_hold_dp, w_hold_dp_nxt;
  logic             r_hold_blank, w_hold_blank_nxt;
  logic [3:0]       r_enable, w_enable_nxt;
  logic [6:0]       r_segs, w_segs_nxt;
  logic             r_decimal, w_decimal_nxt;

  logic [3:0]       w_sel_val;
  logic             w_sel_dp, w_sel_blank;
  logic             w_light;
  logic [3:0]       w_src_val;
  logic             w_src_dp, w_src_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_sel_val   = digits[{r_idx, 2'b00} +: 4];
  assign w_sel_dp    = dp_mask[r_idx];
  assign w_sel_blank = blank_mask[r_idx];

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_hold_val_nxt   = r_hold_val;
    w_hold_dp_nxt    = r_hold_dp;
    w_hold_blank_nxt = r_hold_blank;
    w_light          = 1'b0;
    w_src_val        = r_hold_val;
    w_src_dp         = r_hold_dp;
    w_src_blank      = r_hold_blank;
    w_enable_nxt     = 4'b1111;
    w_segs_nxt       = 7'b1111111;
    w_decimal_nxt    = 1'b1;

    case (r_state)
      ST_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt      = ST_DRIVE;
          w_cnt_nxt        = '0;
          w_hold_val_nxt   = w_sel_val;
          w_hold_dp_nxt    = w_sel_dp;
          w_hold_blank_nxt = w_sel_blank;
          // The first lit cycle loads straight from the inputs being snapshotted
          w_light          = 1'b1;
          w_src_val        = w_sel_val;
          w_src_dp         = w_sel_dp;
          w_src_blank      = w_sel_blank;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == c_drive_last) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
          w_light   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase

    // Anode, cathodes and dp are all derived together so they switch on one edge
    if (w_light && !w_src_blank) begin
      w_enable_nxt  = ~(4'b0001 << r_idx);
      w_segs_nxt    = hex7(w_src_val);
      w_decimal_nxt = ~w_src_dp;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_hold_val   <= 4'd0;
      r_hold_dp    <= 1'b0;
      r_hold_blank <= 1'b0;
      r_enable     <= 4'b1111;
      r_segs       <= 7'b1111111;
      r_decimal    <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_hold_val   <= w_hold_val_nxt;
      r_hold_dp    <= w_hold_dp_nxt;
      r_hold_blank <= w_hold_blank_nxt;
      r_enable     <= w_enable_nxt;
      r_segs       <= w_segs_nxt;
      r_decimal    <= w_decimal_nxt;
    end
  end

  assign enable    = r_enable;
  assign segs      = r_segs;
  assign decimal   = r_decimal;
  assign digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// tb_seg_scan_driver : hex-table vectors, hand corner sequences and randomized
// stimulus checked against a slot-timing model of the display scan.
module tb_seg_scan_driver;
  localparam int R     = 4;
  localparam int B     = 2;
  localparam int SLOT  = R + B;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  enable;
  logic [6:0]  segs;
  logic        decimal;
  logic [1:0]  digit_idx;

  int errors = 0;
  int checks = 0;
  int n = 0;                 // rising edges since the last clr release
  logic [3:0] snap_v  = 4'h0;
  logic       snap_dp = 1'b0;
  logic       snap_bl = 1'b0;

  typedef struct packed {
    logic [3:0] val;
    logic [6:0] exp;
  } vec_t;
  vec_t       vecs    [16];
  logic [6:0] hex_ref [16];

  seg_scan_driver #(
    .REFRESH_CYCLES(R),
    .BLANK_CYCLES  (B),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .blank_mask(blank_mask),
    .enable    (enable),
    .segs      (segs),
    .decimal   (decimal),
    .digit_idx (digit_idx)
  );

  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got hang, expected finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at n=%0d t=%0t", name, got, exp, n, $time);
    end
  endtask

  // Expected {digit_idx, enable, segs, decimal} from the slot position alone
  function automatic logic [13:0] model_out();
    int         m  = n % SLOT;
    int         k  = (n / SLOT) % 4;
    logic [3:0] en = 4'hF;
    logic [6:0] sg = 7'h7F;
    logic       dp = 1'b1;
    if (m >= B && !snap_bl) begin
      en[k] = 1'b0;
      sg    = hex_ref[snap_v];
      dp    = ~snap_dp;
    end
    return {2'(k), en, sg, dp};
  endfunction

  task automatic step();
    logic [15:0] d  = digits;
    logic [3:0]  dm = dp_mask;
    logic [3:0]  bm = blank_mask;
    @(posedge clk);
    n++;
    if (n % SLOT == B) begin
      int k = (n / SLOT) % 4;
      snap_v  = d[4*k +: 4];
      snap_dp = dm[k];
      snap_bl = bm[k];
    end
    #1;
    check("scan", {18'd0, digit_idx, enable, segs, decimal}, {18'd0, model_out()});
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // Holds clr for 30 ns starting away from any edge; checks the async effect
  task automatic do_reset();
    clr = 1'b1;
    #1;
    check("rst_async", {18'd0, digit_idx, enable, segs, decimal},
          {18'd0, 2'd0, 4'hF, 7'h7F, 1'b1});
    #29;
    clr = 1'b0;
    n = 0;
  endtask

  initial begin
    int cnt_dp0;
    int cnt_lit;
    int cnt_two_hot;

    vecs[0]  = '{4'h0, 7'b1000000};
    vecs[1]  = '{4'h1, 7'b1111001};
    vecs[2]  = '{4'h2, 7'b0100100};
    vecs[3]  = '{4'h3, 7'b0110000};
    vecs[4]  = '{4'h4, 7'b0011001};
    vecs[5]  = '{4'h5, 7'b0010010};
    vecs[6]  = '{4'h6, 7'b0000010};
    vecs[7]  = '{4'h7, 7'b1111000};
    vecs[8]  = '{4'h8, 7'b0000000};
    vecs[9]  = '{4'h9, 7'b0010000};
    vecs[10] = '{4'hA, 7'b0001000};
    vecs[11] = '{4'hB, 7'b0000011};
    vecs[12] = '{4'hC, 7'b1000110};
    vecs[13] = '{4'hD, 7'b0100001};
    vecs[14] = '{4'hE, 7'b0000110};
    vecs[15] = '{4'hF, 7'b0001110};
    for (int i = 0; i < 16; i++) hex_ref[vecs[i].val] = vecs[i].exp;

    // Reset and first lit digit
    digits = 16'h1234;
    #5;
    do_reset();
    step();
    check("dark_after_rst", {28'd0, enable}, 32'hF);
    step();
    check("first_lit_en", {28'd0, enable}, 32'b1110);
    check("first_lit_segs", {25'd0, segs}, 32'b0011001);
    run(3);
    check("digit0_last", {28'd0, enable}, 32'b1110);
    step();
    check("digit0_off", {28'd0, enable}, 32'hF);
    run(FRAME - n);

    // Full frame with per-cycle two-hot monitoring
    cnt_lit = 0;
    cnt_two_hot = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (enable != 4'hF) cnt_lit++;
      if ($countones(~enable) > 1) cnt_two_hot++;
    end
    check("frame_lit_cycles", cnt_lit, 16);
    check("frame_two_hot", cnt_two_hot, 0);

    // Snapshot stability on digit 1
    digits = 16'h00A0;
    while (n % FRAME != 2*SLOT - 3) step();
    while (n % FRAME != SLOT + B + 1) step();
    digits = 16'h00F0;
    step();
    check("snap_hold", {25'd0, segs}, 32'b0001000);
    step();
    check("snap_hold_end", {25'd0, segs}, 32'b0001000);
    while (n % FRAME != SLOT + B) step();
    check("snap_next_en", {28'd0, enable}, 32'b1101);
    check("snap_next_segs", {25'd0, segs}, 32'b0001110);

    // Masks
    dp_mask = 4'b0100;
    blank_mask = 4'b1000;
    digits = 16'hB321;
    while (n % FRAME != 0) step();
    cnt_dp0 = 0;
    cnt_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (decimal == 1'b0) cnt_dp0++;
      if (enable != 4'hF) cnt_lit++;
      if (n % FRAME >= 3*SLOT + B)
        check("blank_slot", {21'd0, enable, segs}, {21'd0, 4'hF, 7'h7F});
    end
    check("mask_dp_cycles", cnt_dp0, 4);
    check("mask_lit_cycles", cnt_lit, 12);
    check("mask_frame_wrap", {30'd0, digit_idx}, 32'd0);

    // Mid-scan reset during digit 2 drive
    while (n % FRAME != 2*SLOT + B + 1) step();
    check("pre_rst_en", {28'd0, enable}, 32'b1011);
    do_reset();
    step();
    check("mid_rst_dark", {28'd0, enable}, 32'hF);
    step();
    check("mid_rst_lit", {28'd0, enable}, 32'b1110);

    // Hex table sweep on digit 0, one value per frame
    dp_mask = 4'h0;
    blank_mask = 4'h0;
    while (n % FRAME != 0) step();
    for (int i = 0; i < 16; i++) begin
      digits = 16'($urandom);
      digits[3:0] = vecs[i].val;
      run(B);
      check($sformatf("hex_%h", vecs[i].val), {25'd0, segs}, {25'd0, vecs[i].exp});
      run(FRAME - B);
    end

    // Randomized stimulus against the model, with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 249) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
